sdram_port_arbiter: RTL

//   Shares the single SDRAMController command port between two requesters (0 and 1).

---
 rtl/sdram_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// ============================================================================
// sdram_port_arbiter: two-requester round-robin front end for SDRAMController,
// with an in-order tag FIFO that steers read data back to its issuer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdram_port_arbiter #(
  parameter int AddrWidth = 25,
  parameter int DataWidth = 16,
  parameter int TagDepth  = 4
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 r0Trigger,
  input  logic [AddrWidth-1:0] r0Addr,
  input  logic                 r0Write,
  input  logic [DataWidth-1:0] r0WriteData,
  output logic                 r0Ready,
  output logic [DataWidth-1:0] r0ReadData,
  output logic                 r0ReadDataValid,
  input  logic                 r1Trigger,
  input  logic [AddrWidth-1:0] r1Addr,
  input  logic                 r1Write,
  input  logic [DataWidth-1:0] r1WriteData,
  output logic                 r1Ready,
  output logic [DataWidth-1:0] r1ReadData,
  output logic                 r1ReadDataValid,
  input  logic                 cmdReady,
  output logic                 cmdTrigger,
  output logic [AddrWidth-1:0] cmdAddr,
  output logic                 cmdWrite,
  output logic [DataWidth-1:0] cmdWriteData,
  input  logic [DataWidth-1:0] cmdReadData,
  input  logic                 cmdReadDataValid,
  output logic                 errUnderflow
);

  localparam int PtrW = $clog2(TagDepth);
  localparam int CntW = $clog2(TagDepth + 1);

  logic                prio;
  logic [TagDepth-1:0] tags;
  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [CntW-1:0]     count;
  logic                underflow_flag;

  logic full, empty, elig0, elig1, grant_valid, grant_id;
  logic accept, push, pop, head_tag;

  // Full is taken from the registered count, so a same-cycle pop cannot unblock a read.
  assign full  = (count == CntW'(TagDepth));
  assign empty = (count == '0);
  assign elig0 = r0Trigger & (r0Write | ~full);
  assign elig1 = r1Trigger & (r1Write | ~full);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (elig0 && elig1) begin
      grant_valid = 1'b1;
      grant_id    = prio;
    end else if (elig0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (elig1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign cmdTrigger   = rst_ & grant_valid;
  assign cmdAddr      = grant_id ? r1Addr      : r0Addr;
  assign cmdWrite     = grant_id ? r1Write     : r0Write;
  assign cmdWriteData = grant_id ? r1WriteData : r0WriteData;

  assign accept  = cmdTrigger & cmdReady;
  assign r0Ready = accept & ~grant_id;
  assign r1Ready = accept &  grant_id;
  assign push    = accept & ~cmdWrite;

  assign pop             = cmdReadDataValid & ~empty;
  assign head_tag        = tags[rd_ptr];
  assign r0ReadDataValid = rst_ & pop & ~head_tag;
  assign r1ReadDataValid = rst_ & pop &  head_tag;
  assign r0ReadData      = cmdReadData;
  assign r1ReadData      = cmdReadData;
  assign errUnderflow    = underflow_flag;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prio           <= 1'b0;
      tags           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      underflow_flag <= 1'b0;
    end else begin
      if (accept) prio <= ~grant_id;
      if (push) begin
        tags[wr_ptr] <= grant_id;
        wr_ptr       <= wr_ptr + PtrW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PtrW'(1);
      if (push && !pop)      count <= count + CntW'(1);
      else if (pop && !push) count <= count - CntW'(1);
      if (cmdReadDataValid && empty) underflow_flag <= 1'b1;
    end
  end

endmodule

`default_nettype wire
